// File: rtl/branch_sequencer.sv
// Fetch-PC sequencer: resolves B / CBZ / CBNZ / B.cond, redirects the PC and drives a flush window.
// Optional branch statistics counters are enabled with the BRANCH_STATS_EN macro.
module branch_sequencer #(
  parameter int                  ADDRSIZE    = 64,
  parameter logic [ADDRSIZE-1:0] RESETPC     = '0,
  parameter int                  FLUSHCYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flags_we,
  input  logic [3:0]          flags_in,
  input  logic                br_valid,
  output logic                br_ready,
  input  logic [10:0]         br_opcode,
  input  logic [4:0]          br_rd,
  input  logic                br_zero,
  input  logic [ADDRSIZE-1:0] br_target,
  output logic [ADDRSIZE-1:0] pc,
  output logic [3:0]          flags,
  output logic                flush,
  output logic                taken
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]         stat_total,
  output logic [31:0]         stat_taken
`endif
);

  if (FLUSHCYCLES < 1 || FLUSHCYCLES > 15) begin : g_bad_flushcycles
    $error("branch_sequencer: FLUSHCYCLES must be within 1..15");
  end

  localparam logic [ADDRSIZE-1:0] PC_STEP   = ADDRSIZE'(4);
  localparam logic [3:0]          CNT_START = 4'(FLUSHCYCLES - 1);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDRSIZE-1:0] pc_q, pc_d;
  logic [3:0]          flags_q, flags_d;
  logic                flush_q, flush_d;
  logic                taken_q, taken_d;

  logic                is_b_s, is_cbz_s, is_cbnz_s, is_bcond_s;
  logic [3:0]          eval_flags_s;
  logic                cond_true_s;
  logic                br_taken_s;
  logic                accept_s;
  logic                unused_bits_s;

  // Evaluates a 4-bit condition code against {N,Z,V,C}.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzvc);
    logic n, z, v, c;
    logic res;
    n = nzvc[3];
    z = nzvc[2];
    v = nzvc[1];
    c = nzvc[0];
    case (cond)
      4'h0:    res = z;
      4'h1:    res = !z;
      4'h2:    res = c;
      4'h3:    res = !c;
      4'h4:    res = n;
      4'h5:    res = !n;
      4'h6:    res = v;
      4'h7:    res = !v;
      4'h8:    res = !z && c;
      4'h9:    res = !(!z && c);
      4'hA:    res = (n == v);
      4'hB:    res = (n != v);
      4'hC:    res = !z && (n == v);
      4'hD:    res = !(!z && (n == v));
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  assign unused_bits_s = ^{br_rd[4], br_opcode[2:0]};

  // Branch decode, flag forwarding and taken resolution.
  always_comb begin
    is_b_s       = (br_opcode[10:5] == 6'b000101);
    is_cbz_s     = (br_opcode[10:3] == 8'b10110100);
    is_cbnz_s    = (br_opcode[10:3] == 8'b10110101);
    is_bcond_s   = (br_opcode[10:3] == 8'b01010100);
    eval_flags_s = flags_we ? flags_in : flags_q;
    cond_true_s  = cond_eval(br_rd[3:0], eval_flags_s);
    if (is_b_s) begin
      br_taken_s = 1'b1;
    end else if (is_cbz_s) begin
      br_taken_s = br_zero;
    end else if (is_cbnz_s) begin
      br_taken_s = !br_zero;
    end else if (is_bcond_s) begin
      br_taken_s = cond_true_s;
    end else begin
      br_taken_s = 1'b0;
    end
    br_ready = (state_q == ST_RUN) && !stall;
    accept_s = br_valid && br_ready;
  end

  // Next-state logic for the PC, flags and the RUN/FLUSH sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    flush_d = flush_q;
    taken_d = 1'b0;
    flags_d = flags_we ? flags_in : flags_q;
    case (state_q)
      ST_RUN: begin
        if (accept_s && br_taken_s) begin
          pc_d    = br_target;
          taken_d = 1'b1;
          flush_d = 1'b1;
          cnt_d   = CNT_START;
          state_d = ST_FLUSH;
        end else if (!stall) begin
          pc_d = pc_q + PC_STEP;
        end else begin
          pc_d = pc_q;
        end
      end
      ST_FLUSH: begin
        // The window length is fixed: the counter runs even while fetch is stalled.
        if (cnt_q == 4'd0) begin
          state_d = ST_RUN;
          flush_d = 1'b0;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          flush_d = 1'b1;
        end
        if (!stall) begin
          pc_d = pc_q + PC_STEP;
        end else begin
          pc_d = pc_q;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = 4'd0;
        flush_d = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
      pc_q    <= RESETPC;
      flags_q <= 4'd0;
      flush_q <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
      flush_q <= flush_d;
      taken_q <= taken_d;
    end
  end

  assign pc    = pc_q;
  assign flags = flags_q;
  assign flush = flush_q;
  assign taken = taken_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_total_q, stat_total_d;
  logic [31:0] stat_taken_q, stat_taken_d;
  logic        is_branch_s;

  // Saturating counters of accepted and taken branches; unknown opcodes are not counted.
  always_comb begin
    is_branch_s  = is_b_s || is_cbz_s || is_cbnz_s || is_bcond_s;
    stat_total_d = stat_total_q;
    stat_taken_d = stat_taken_q;
    if (accept_s && is_branch_s && (stat_total_q != 32'hFFFF_FFFF)) begin
      stat_total_d = stat_total_q + 32'd1;
    end else begin
      stat_total_d = stat_total_q;
    end
    if (accept_s && br_taken_s && (stat_taken_q != 32'hFFFF_FFFF)) begin
      stat_taken_d = stat_taken_q + 32'd1;
    end else begin
      stat_taken_d = stat_taken_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_total_q <= 32'd0;
      stat_taken_q <= 32'd0;
    end else begin
      stat_total_q <= stat_total_d;
      stat_taken_q <= stat_taken_d;
    end
  end

  assign stat_total = stat_total_q;
  assign stat_taken = stat_taken_q;
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Scoreboard bench for branch_sequencer: a cycle model pushes expected outputs as stimulus is driven,
// and they are popped and compared one cycle later. Define BRANCH_STATS_EN to also check the counters.
module tb_branch_sequencer;

  localparam int AW = 64;
  localparam int FC = 2;

  localparam logic [10:0] OP_B     = 11'b00010100000;
  localparam logic [10:0] OP_CBZ   = 11'b10110100000;
  localparam logic [10:0] OP_CBNZ  = 11'b10110101000;
  localparam logic [10:0] OP_BCOND = 11'b01010100000;
  localparam logic [10:0] OP_OTHER = 11'b11111000000;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall, flags_we, br_valid, br_zero;
  logic [3:0]    flags_in;
  logic [10:0]   br_opcode;
  logic [4:0]    br_rd;
  logic [AW-1:0] br_target;
  logic          br_ready, flush, taken;
  logic [AW-1:0] pc;
  logic [3:0]    flags;
`ifdef BRANCH_STATS_EN
  logic [31:0]   stat_total, stat_taken;
`endif

  branch_sequencer #(.ADDRSIZE(AW), .RESETPC(64'd0), .FLUSHCYCLES(FC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flags_we(flags_we), .flags_in(flags_in),
    .br_valid(br_valid), .br_ready(br_ready), .br_opcode(br_opcode), .br_rd(br_rd),
    .br_zero(br_zero), .br_target(br_target), .pc(pc), .flags(flags),
    .flush(flush), .taken(taken)
`ifdef BRANCH_STATS_EN
    , .stat_total(stat_total), .stat_taken(stat_taken)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] pc;
    logic          flush;
    logic          taken;
    logic [3:0]    flags;
    logic [31:0]   total;
    logic [31:0]   tkn;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;

  logic [AW-1:0] m_pc;
  logic [3:0]    m_flags;
  int            m_left;
  logic [31:0]   m_total, m_tkn;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference decode: conditions are paired as (base, inverted base), 0xE/0xF never taken.
  function automatic logic m_taken_f(input logic [10:0] opc, input logic [4:0] rd,
                                     input logic zero, input logic [3:0] f);
    logic base;
    if (opc[10:5] == 6'b000101) return 1'b1;
    if (opc[10:3] == 8'b10110100) return zero;
    if (opc[10:3] == 8'b10110101) return !zero;
    if (opc[10:3] == 8'b01010100) begin
      case (rd[3:1])
        3'd0: base = f[2];
        3'd1: base = f[0];
        3'd2: base = f[3];
        3'd3: base = f[1];
        3'd4: base = f[0] & ~f[2];
        3'd5: base = ~(f[3] ^ f[1]);
        3'd6: base = ~(f[3] ^ f[1]) & ~f[2];
        default: return 1'b0;
      endcase
      return rd[0] ? !base : base;
    end
    return 1'b0;
  endfunction

  function automatic logic m_is_br(input logic [10:0] opc);
    return (opc[10:5] == 6'b000101) || (opc[10:4] == 7'b1011010) || (opc[10:3] == 8'b01010100);
  endfunction

  task automatic model_reset();
    m_pc = 64'd0; m_flags = 4'd0; m_left = 0; m_total = 32'd0; m_tkn = 32'd0;
  endtask

  task automatic compare_outputs(input exp_t e);
    check_eq("pc", pc, e.pc);
    check_eq("flush", {63'd0, flush}, {63'd0, e.flush});
    check_eq("taken", {63'd0, taken}, {63'd0, e.taken});
    check_eq("flags", {60'd0, flags}, {60'd0, e.flags});
`ifdef BRANCH_STATS_EN
    check_eq("stat_total", {32'd0, stat_total}, {32'd0, e.total});
    check_eq("stat_taken", {32'd0, stat_taken}, {32'd0, e.tkn});
`endif
  endtask

  // One clock: drive inputs, check ready, push model prediction, then pop after the edge.
  task automatic cycle(input logic st, input logic we, input logic [3:0] fl, input logic vld,
                       input logic [10:0] opc, input logic [4:0] rd, input logic zero,
                       input logic [AW-1:0] tgt);
    logic exp_ready, acc, tk;
    exp_t e;
    stall = st; flags_we = we; flags_in = fl; br_valid = vld;
    br_opcode = opc; br_rd = rd; br_zero = zero; br_target = tgt;
    #1;
    exp_ready = (m_left == 0) && !st;
    check_eq("br_ready", {63'd0, br_ready}, {63'd0, exp_ready});
    acc = vld && exp_ready;
    tk  = acc && m_taken_f(opc, rd, zero, we ? fl : m_flags);
    if (acc && m_is_br(opc) && m_total != 32'hFFFF_FFFF) m_total = m_total + 32'd1;
    if (tk && m_tkn != 32'hFFFF_FFFF) m_tkn = m_tkn + 32'd1;
    if (we) m_flags = fl;
    if (m_left > 0) begin
      m_left--;
      if (!st) m_pc = m_pc + 64'd4;
    end else if (tk) begin
      m_pc = tgt;
      m_left = FC;
    end else if (!st) begin
      m_pc = m_pc + 64'd4;
    end
    e.pc = m_pc; e.flush = (m_left > 0); e.taken = tk; e.flags = m_flags;
    e.total = m_total; e.tkn = m_tkn;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 64'd0, 64'd1);
    end else begin
      compare_outputs(exp_q.pop_front());
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'd0, 1'b0, 11'd0, 5'd0, 1'b0, 64'd0);
  endtask

  task automatic branch(input logic [10:0] opc, input logic [4:0] rd, input logic zero,
                        input logic [AW-1:0] tgt, input logic we, input logic [3:0] fl);
    cycle(1'b0, we, fl, 1'b1, opc, rd, zero, tgt);
    idle(FC);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flags_we = 1'b0; flags_in = 4'd0; br_valid = 1'b0;
    br_opcode = 11'd0; br_rd = 5'd0; br_zero = 1'b0; br_target = 64'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_pc", pc, 64'd0);
    check_eq("rst_flush", {63'd0, flush}, 64'd0);
    check_eq("rst_taken", {63'd0, taken}, 64'd0);
    check_eq("rst_flags", {60'd0, flags}, 64'd0);
    check_eq("rst_ready", {63'd0, br_ready}, 64'd1);
    rst = 1'b0;

    idle(2);
    check_eq("pc_seq", pc, 64'd8);
    cycle(1'b0, 1'b0, 4'd0, 1'b1, OP_B, 5'd0, 1'b0, 64'h100);
    check_eq("b_pc", pc, 64'h100);
    check_eq("b_taken", {63'd0, taken}, 64'd1);
    idle(FC);
    check_eq("b_after_pc", pc, 64'h108);
    check_eq("b_after_flush", {63'd0, flush}, 64'd0);

    branch(OP_CBZ, 5'd3, 1'b0, 64'h2000, 1'b0, 4'd0);
    branch(OP_CBNZ, 5'd3, 1'b0, 64'h2000, 1'b0, 4'd0);
    branch(OP_CBZ, 5'd3, 1'b1, 64'h3000, 1'b0, 4'd0);

    branch(OP_BCOND, 5'h0, 1'b0, 64'h4000, 1'b1, 4'b0100);
    branch(OP_BCOND, 5'h1, 1'b0, 64'h5000, 1'b1, 4'b0100);
    branch(OP_BCOND, 5'hE, 1'b0, 64'h6000, 1'b1, 4'b0100);
    branch(OP_BCOND, 5'h1, 1'b0, 64'h7000, 1'b0, 4'd0);

    for (int c = 0; c < 16; c++) begin
      logic [3:0] fr;
      fr = 4'($urandom_range(0, 15));
      branch(OP_BCOND, 5'(c), 1'b0, 64'h8000 + 64'(c) * 64'h10, 1'b1, fr);
      fr = 4'($urandom_range(0, 15));
      cycle(1'b0, 1'b1, fr, 1'b0, 11'd0, 5'd0, 1'b0, 64'd0);
      branch(OP_BCOND, 5'(c), 1'b0, 64'h9000 + 64'(c) * 64'h10, 1'b0, 4'd0);
    end

    cycle(1'b1, 1'b0, 4'd0, 1'b1, OP_B, 5'd0, 1'b0, 64'hA000);
    cycle(1'b1, 1'b0, 4'd0, 1'b1, OP_B, 5'd0, 1'b0, 64'hA000);
    cycle(1'b0, 1'b0, 4'd0, 1'b1, OP_B, 5'd0, 1'b0, 64'hA000);
    check_eq("stall_release_pc", pc, 64'hA000);
    cycle(1'b1, 1'b0, 4'd0, 1'b0, 11'd0, 5'd0, 1'b0, 64'd0);
    cycle(1'b1, 1'b0, 4'd0, 1'b0, 11'd0, 5'd0, 1'b0, 64'd0);
    idle(2);

    branch(OP_OTHER, 5'd0, 1'b0, 64'hB000, 1'b0, 4'd0);

    branch(OP_B, 5'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 4'd0);
    check_eq("wrap_pc", pc, 64'd0);

    cycle(1'b0, 1'b0, 4'd0, 1'b1, OP_B, 5'd0, 1'b0, 64'hC000);
    rst = 1'b1;
    #1;
    check_eq("midflush_rst_pc", pc, 64'd0);
    check_eq("midflush_rst_flush", {63'd0, flush}, 64'd0);
    check_eq("midflush_rst_taken", {63'd0, taken}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    idle(3);

    check_eq("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Sequences the fetch PC around branch resolution: holds the PC and the NZVC flags register.
- Accepts one resolved-branch request at a time over a valid/ready handshake and evaluates B, CBZ/CBNZ and B.cond.
- Redirects the PC on a taken branch and drives a fixed-length pipeline flush window.
- Sits between decode/execute and the fetch stage; the sole owner of PC updates.

Parameters:
- ADDRSIZE, 64, width of PC and branch target.
- RESETPC, 0, PC value loaded on reset.
- FLUSHCYCLES, 2, cycles of flush after a taken branch; legal range 1..15, checked at elaboration.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- stall  in  1  fetch stall; holds PC.
- flags_we  in  1  write enable for the flags register.
- flags_in  in  4  new flags {N,Z,V,C}.
- br_valid  in  1  branch request valid.
- br_ready  out  1  sequencer can accept a request.
- br_opcode  in  11  instruction opcode field [31:21].
- br_rd  in  5  Rt/cond field; cond = br_rd[3:0].
- br_zero  in  1  tested register == 0 (CBZ/CBNZ).
- br_target  in  ADDRSIZE  computed branch target.
- pc  out  ADDRSIZE  current fetch PC.
- flags  out  4  registered flags.
- flush  out  1  squash younger pipeline stages.
- taken  out  1  one-cycle pulse: the accepted branch was taken.

Behaviour:
- Reset (async, any state, including mid-flush):
  - pc = RESETPC, flags = 0, flush = 0, taken = 0, state = RUN, flush counter = 0.
  - br_ready follows state: 1 when stall = 0.
- Decode:
  - B: br_opcode[10:5] == 6'b000101.
  - CBZ: br_opcode[10:3] == 8'b10110100, taken iff br_zero = 1.
  - CBNZ: br_opcode[10:3] == 8'b10110101, taken iff br_zero = 0.
  - B.cond: br_opcode[10:3] == 8'b01010100, taken per cond:
    - 0 EQ Z; 1 NE !Z; 2 HS C; 3 LO !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
    - 8 HI !Z&C; 9 LS !(!Z&C); A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE !(!Z&(N==V)).
    - E, F never taken.
  - Any other opcode is accepted and treated as not taken (no PC redirect, no flush).
- Flag forwarding:
  - B.cond evaluates flags_in if flags_we = 1 in the accept cycle, else the registered flags.
  - The flags register is written whenever flags_we = 1, in any state.
- States: RUN, FLUSH.
  - RUN:
    - br_ready = !stall.
    - Accept when br_valid & br_ready.
    - Taken: next pc = br_target; taken = 1 next cycle; flush = 1 next cycle; counter = FLUSHCYCLES-1; go to FLUSH.
    - Not taken or no accept: pc += 4 when stall = 0, held when stall = 1.
  - FLUSH:
    - br_ready = 0, flush = 1.
    - pc += 4 when stall = 0; the counter decrements every cycle regardless of stall.
    - Counter == 0: return to RUN; flush deasserts that next cycle.
- Latency:
  - pc equals the target exactly one cycle after the accept edge.
  - taken is high for exactly that one cycle.
  - flush is high for exactly FLUSHCYCLES cycles, starting that same cycle.
- Simultaneous events: stall and br_valid both high in RUN → no accept (br_ready = 0), PC held.
- Wrap-around: pc + 4 wraps modulo 2^ADDRSIZE silently.
- Request hold: br_valid must stay high, with stable payload, until accepted.

Optional Feature:
- BRANCH_STATS_EN defined:
  - Adds outputs stat_total[31:0] and stat_taken[31:0], reset to 0.
  - stat_total increments on every accepted B, CBZ, CBNZ or B.cond; stat_taken increments on every taken accept.
  - Both saturate at 32'hFFFFFFFF.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then 3 cycles with no stall → pc = 0, 4, 8, 12; flush = 0; br_ready = 1.
- B to 0x100 accepted at pc = 8 → next cycle pc = 0x100, taken = 1 for one cycle, flush = 1 for 2 cycles, br_ready = 0 for 2 cycles, then pc = 0x108.
- CBZ with br_zero = 0 → not taken, pc += 4, no flush. CBNZ with br_zero = 0 → taken to br_target.
- flags_we = 1, flags_in = 4'b0100 in the same cycle as B.EQ (cond 0) → taken. Same with cond B.NE → not taken. cond E → never taken.
- stall = 1 with br_valid = 1 → br_ready = 0, pc held. Release stall → accepted next cycle. Assert rst mid-FLUSH → pc = RESETPC, flush = 0 immediately.
- BRANCH_STATS_EN: 5 branches with 3 taken → stat_total = 5, stat_taken = 3. Unknown opcode accepted → counters unchanged.
